cond_flag_ctrl: RTL and testbench

Execute-stage condition-flag controller for the pipelined core. It holds the two architectural flag groups that feed the condition-check stage, and consumes that stage's CondEx to decide whether the instruction in Execute commits. It gates the instruction's register, memory and PC-source write strobes into registered Memory-stage strobes, updates the flags only for executing instructions, and kills the two instructions in the shadow of a taken branch. It also counts condition-squashed instructions for performance monitoring.

---
 rtl/cond_flag_ctrl_if.sv | 36 +++
 rtl/cond_flag_ctrl.sv | 92 +++++++++
 tb/tb_cond_flag_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cond_flag_ctrl_if.sv
// Execute-stage condition-flag controller bus: decode strobes and flag writes in,
// architectural flags, gated Memory-stage strobes, kill indication and skip counter out.
interface cond_flag_ctrl_if #(
    parameter int FLAG_W = 2,
    parameter int CNT_W  = 8
);
    logic              Stall;
    logic              Flush;
    logic              ValidE;
    logic              CondEx;
    logic [1:0]        FlagWE;
    logic [FLAG_W-1:0] ALUFlags1;
    logic [FLAG_W-1:0] ALUFlags2;
    logic              PCSE;
    logic              RegWE;
    logic              MemWE;
    logic [FLAG_W-1:0] Flags1;
    logic [FLAG_W-1:0] Flags2;
    logic              PCSrcM;
    logic              RegWriteM;
    logic              MemWriteM;
    logic              KillE;
    logic [CNT_W-1:0]  SkipCount;

    modport master (
        output Stall, Flush, ValidE, CondEx, FlagWE, ALUFlags1, ALUFlags2,
               PCSE, RegWE, MemWE,
        input  Flags1, Flags2, PCSrcM, RegWriteM, MemWriteM, KillE, SkipCount
    );

    modport slave (
        input  Stall, Flush, ValidE, CondEx, FlagWE, ALUFlags1, ALUFlags2,
               PCSE, RegWE, MemWE,
        output Flags1, Flags2, PCSrcM, RegWriteM, MemWriteM, KillE, SkipCount
    );
endinterface

// File: rtl/cond_flag_ctrl.sv
// Commits or squashes the Execute instruction from CondEx, owns the two flag groups,
// registers gated Memory-stage strobes and kills the two slots behind a taken branch.
module cond_flag_ctrl #(
    parameter int FLAG_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    cond_flag_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, KILL1, KILL2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state, state_nxt;
    logic              exec_e;
    logic              skip_e;
    logic [FLAG_W-1:0] flags1_q, flags2_q;
    logic              pcsrc_q, regwrite_q, memwrite_q;
    logic [CNT_W-1:0]  skip_q;

    // Flush kills the slot outright; kill states squash the branch shadow.
    assign exec_e = bus.ValidE & bus.CondEx & (state == RUN) & ~bus.Flush;
    assign skip_e = bus.ValidE & ~bus.CondEx & (state == RUN) & ~bus.Stall & ~bus.Flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (bus.Flush) begin
            state_nxt = RUN;
        end else if (!bus.Stall) begin
            unique case (state)
                RUN:     if (exec_e && bus.PCSE) state_nxt = KILL1;
                KILL1:   state_nxt = KILL2;
                KILL2:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags1_q <= '0;
            flags2_q <= '0;
        end else begin
            if (exec_e && bus.FlagWE[0] && !bus.Stall) flags1_q <= bus.ALUFlags1;
            if (exec_e && bus.FlagWE[1] && !bus.Stall) flags2_q <= bus.ALUFlags2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (bus.Flush) begin
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (!bus.Stall) begin
            pcsrc_q    <= bus.PCSE  & exec_e;
            regwrite_q <= bus.RegWE & exec_e;
            memwrite_q <= bus.MemWE & exec_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= '0;
        end else if (skip_e && skip_q != CNT_MAX) begin
            skip_q <= skip_q + CNT_W'(1);
        end
    end

    assign bus.Flags1    = flags1_q;
    assign bus.Flags2    = flags2_q;
    assign bus.PCSrcM    = pcsrc_q;
    assign bus.RegWriteM = regwrite_q;
    assign bus.MemWriteM = memwrite_q;
    assign bus.KillE     = (state != RUN);
    assign bus.SkipCount = skip_q;
endmodule

// File: tb/tb_cond_flag_ctrl.sv
// Directed bench for cond_flag_ctrl: reset, flag writes, branch shadow kill,
// stall/flush priority, stalled kill sequence, counter saturation and async reset.
module tb_cond_flag_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cond_flag_ctrl_if #(.FLAG_W(2), .CNT_W(8)) bus ();

    cond_flag_ctrl #(.FLAG_W(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic idle();
        bus.Stall = 0; bus.Flush = 0; bus.ValidE = 0; bus.CondEx = 0;
        bus.FlagWE = 2'b00; bus.ALUFlags1 = 2'b00; bus.ALUFlags2 = 2'b00;
        bus.PCSE = 0; bus.RegWE = 0; bus.MemWE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            bus.Stall = 1'($urandom); bus.Flush = 1'($urandom); bus.ValidE = 1'($urandom);
            bus.CondEx = 1'($urandom); bus.FlagWE = 2'($urandom);
            bus.ALUFlags1 = 2'($urandom); bus.ALUFlags2 = 2'($urandom);
            bus.PCSE = 1'($urandom); bus.RegWE = 1'($urandom); bus.MemWE = 1'($urandom);
            tick();
            chk("reset_outs", {bus.Flags1, bus.Flags2, bus.PCSrcM, bus.RegWriteM,
                               bus.MemWriteM, bus.KillE}, 0);
            chk("reset_cnt", bus.SkipCount, 0);
        end
        idle();
        rst_n = 1;
        tick(); tick();
        chk("idle_outs", {bus.Flags1, bus.Flags2, bus.PCSrcM, bus.RegWriteM,
                          bus.MemWriteM, bus.KillE}, 0);
        chk("idle_cnt", bus.SkipCount, 0);
    endtask

    task automatic test_flags();
        bus.ValidE = 1; bus.CondEx = 1; bus.FlagWE = 2'b01;
        bus.ALUFlags1 = 2'b10; bus.ALUFlags2 = 2'b11;
        tick();
        chk("flag1_write", bus.Flags1, 2'b10);
        chk("flag2_nowrite", bus.Flags2, 2'b00);
        bus.CondEx = 0; bus.FlagWE = 2'b11; bus.ALUFlags1 = 2'b01;
        tick();
        chk("condfalse_f1", bus.Flags1, 2'b10);
        chk("condfalse_f2", bus.Flags2, 2'b00);
        chk("condfalse_cnt", bus.SkipCount, 1);
        bus.CondEx = 1; bus.FlagWE = 2'b10; bus.ALUFlags1 = 2'b01; bus.ALUFlags2 = 2'b01;
        tick();
        chk("flag2_write_f1", bus.Flags1, 2'b10);
        chk("flag2_write_f2", bus.Flags2, 2'b01);
        chk("flag2_write_cnt", bus.SkipCount, 1);
        idle();
    endtask

    task automatic test_branch();
        bus.ValidE = 1; bus.CondEx = 1; bus.PCSE = 1; bus.RegWE = 1;
        tick(); // N+1
        chk("br_pcsrc", bus.PCSrcM, 1);
        chk("br_regw", bus.RegWriteM, 1);
        chk("br_kill1", bus.KillE, 1);
        bus.PCSE = 0; bus.RegWE = 1; bus.MemWE = 1; bus.FlagWE = 2'b11;
        bus.ALUFlags1 = 2'b11; bus.ALUFlags2 = 2'b11;
        tick(); // N+2
        chk("sh1_strobes", {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM}, 0);
        chk("sh1_kill", bus.KillE, 1);
        bus.CondEx = 0;
        tick(); // N+3
        chk("sh2_strobes", {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM}, 0);
        chk("sh2_kill", bus.KillE, 0);
        chk("sh_flags", {bus.Flags1, bus.Flags2}, 4'b1001);
        chk("sh_cnt", bus.SkipCount, 1);
        idle();
        bus.ValidE = 1; bus.CondEx = 1; bus.RegWE = 1;
        tick();
        chk("run_again", bus.RegWriteM, 1);
        idle();
    endtask

    task automatic test_stall_flush();
        bus.ValidE = 1; bus.CondEx = 1; bus.MemWE = 1;
        tick();
        chk("mem_set", bus.MemWriteM, 1);
        bus.Stall = 1; bus.MemWE = 0; bus.RegWE = 1; bus.FlagWE = 2'b11;
        bus.ALUFlags1 = 2'b00; bus.ALUFlags2 = 2'b10;
        tick();
        chk("stall_hold_mem", bus.MemWriteM, 1);
        chk("stall_hold_reg", bus.RegWriteM, 0);
        chk("stall_flags", {bus.Flags1, bus.Flags2}, 4'b1001);
        bus.CondEx = 0;
        tick();
        chk("stall_nocount", bus.SkipCount, 1);
        bus.CondEx = 1; bus.Flush = 1; bus.MemWE = 1;
        tick();
        chk("flush_mem", bus.MemWriteM, 0);
        chk("flush_flags", {bus.Flags1, bus.Flags2}, 4'b1001);
        bus.Stall = 0; bus.CondEx = 0;
        tick();
        chk("flush_nocount", bus.SkipCount, 1);
        bus.CondEx = 1; bus.PCSE = 1; bus.FlagWE = 2'b00;
        tick();
        chk("flush_br_pc", bus.PCSrcM, 0);
        chk("flush_br_kill", bus.KillE, 0);
        idle();
    endtask

    task automatic test_kill_stall();
        bus.ValidE = 1; bus.CondEx = 1; bus.PCSE = 1;
        tick();
        chk("ks_kill1", bus.KillE, 1);
        bus.PCSE = 0; bus.Stall = 1;
        tick();
        chk("ks_stall1", bus.KillE, 1);
        tick();
        chk("ks_stall2", bus.KillE, 1);
        chk("ks_pc_hold", bus.PCSrcM, 1);
        bus.Stall = 0;
        tick();
        chk("ks_kill2", bus.KillE, 1);
        chk("ks_strobes", {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM}, 0);
        bus.Flush = 1;
        tick();
        chk("ks_flush", bus.KillE, 0);
        idle();
    endtask

    task automatic test_saturation();
        logic [7:0] exp_cnt;
        exp_cnt = 8'd1;
        bus.ValidE = 1; bus.CondEx = 0;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
            if (i == 253 || i >= 256) chk("sat_cnt", bus.SkipCount, exp_cnt);
        end
        chk("sat_final", bus.SkipCount, 255);
        bus.CondEx = 1; bus.PCSE = 1; bus.RegWE = 1;
        tick();
        chk("pre_rst_kill", bus.KillE, 1);
        idle();
        #2 rst_n = 0;
        #1;
        chk("async_cnt", bus.SkipCount, 0);
        chk("async_outs", {bus.PCSrcM, bus.RegWriteM, bus.KillE, bus.Flags1, bus.Flags2}, 0);
        #3 rst_n = 1;
        tick();
        chk("post_rst_kill", bus.KillE, 0);
        bus.ValidE = 1; bus.CondEx = 1; bus.RegWE = 1;
        tick();
        chk("post_rst_run", bus.RegWriteM, 1);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_flags();
        test_branch();
        test_stall_flush();
        test_kill_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
